// File: rtl/spaceship_pkg.sv
// Shared encodings for the weapon controller: salvo modes, salvo FSM states
// and the fixed spread width.
package spaceship_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SPREAD = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  localparam int SPREAD_SHOTS = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    GAP      = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

endpackage

// File: rtl/button_conditioner.sv
// Raw async button -> 2-flop sync -> debounced level -> one-cycle pulse on
// the debounced rising edge.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter of remaining disagreeing samples; any agreeing sample reloads it.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = CNT_RELOAD;
    if (sync2_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= CNT_RELOAD;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_rise = rise_q;

endmodule

// File: rtl/spaceship_weapon_controller.sv
// Ship weapon controller: conditioned rotate/fire buttons, wrap-around heading
// register and the salvo FSM feeding the projectile manager over valid/ready.
//
// state    | meaning
// IDLE     | waiting for a fire pulse; mode and heading latched on it
// ISSUE    | shot_valid high, holding angle/mode until accepted
// GAP      | burst spacing between accepted shot and next request
// COOLDOWN | post-salvo hold-off, fire pulses ignored
module spaceship_weapon_controller #(
  parameter int ANGLE_STEPS     = 16,
  parameter int ANGLE_W         = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BURST_COUNT     = 3,
  parameter int BURST_GAP       = 2,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rotate_left,
  input  logic               rotate_right,
  input  logic               fire,
  input  logic [1:0]         mode,
  input  logic               shot_ready,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               shot_valid,
  output logic [ANGLE_W-1:0] shot_angle,
  output logic [1:0]         shot_mode,
  output logic               busy
);
  import spaceship_pkg::*;

  localparam int SHOT_MAX = (BURST_COUNT > SPREAD_SHOTS) ? BURST_COUNT : SPREAD_SHOTS;
  localparam int SHOT_W   = $clog2(SHOT_MAX + 1);
  localparam int GAP_W    = (BURST_GAP > 0) ? $clog2(BURST_GAP + 1) : 1;
  localparam int CD_W     = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(ANGLE_STEPS - 1);

  function automatic logic [ANGLE_W-1:0] ang_inc(input logic [ANGLE_W-1:0] a);
    return (a == ANGLE_MAX) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [ANGLE_W-1:0] ang_dec(input logic [ANGLE_W-1:0] a);
    return (a == '0) ? ANGLE_MAX : a - 1'b1;
  endfunction

  logic left_pulse, right_pulse, fire_pulse;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .reset(reset), .btn_raw(rotate_left), .btn_rise(left_pulse));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .reset(reset), .btn_raw(rotate_right), .btn_rise(right_pulse));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire (
    .clk(clk), .reset(reset), .btn_raw(fire), .btn_rise(fire_pulse));

  logic [ANGLE_W-1:0] angle_q, angle_d;

  always_comb begin
    angle_d = angle_q;
    if (left_pulse && !right_pulse)      angle_d = ang_dec(angle_q);
    else if (right_pulse && !left_pulse) angle_d = ang_inc(angle_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) angle_q <= '0;
    else        angle_q <= angle_d;
  end

  state_e             state_q;
  logic               shot_valid_q, busy_q;
  logic [ANGLE_W-1:0] shot_angle_q;
  logic [1:0]         shot_mode_q;
  logic [SHOT_W-1:0]  shot_idx_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [CD_W-1:0]    cd_cnt_q;
  logic               last_shot;

  // shot_mode_q only ever holds single/spread/burst; mode 11 is folded into single.
  assign last_shot = (shot_mode_q == MODE_SINGLE) ||
                     (shot_mode_q == MODE_SPREAD && shot_idx_q == SHOT_W'(SPREAD_SHOTS - 1)) ||
                     (shot_mode_q == MODE_BURST  && shot_idx_q == SHOT_W'(BURST_COUNT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shot_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      shot_angle_q <= '0;
      shot_mode_q  <= MODE_SINGLE;
      shot_idx_q   <= '0;
      gap_cnt_q    <= '0;
      cd_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire_pulse) begin
            state_q      <= ISSUE;
            shot_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            shot_idx_q   <= '0;
            shot_mode_q  <= (mode == MODE_SPREAD || mode == MODE_BURST) ? mode : MODE_SINGLE;
            shot_angle_q <= (mode == MODE_SPREAD) ? ang_dec(angle_q) : angle_q;
          end
        end
        ISSUE: begin
          if (shot_ready) begin
            shot_idx_q <= shot_idx_q + 1'b1;
            if (last_shot) begin
              shot_valid_q <= 1'b0;
              if (COOLDOWN_CYCLES == 0) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q  <= COOLDOWN;
                cd_cnt_q <= CD_W'(COOLDOWN_CYCLES - 1);
              end
            end else if (shot_mode_q == MODE_SPREAD) begin
              shot_angle_q <= ang_inc(shot_angle_q);
            end else if (BURST_GAP != 0) begin
              state_q      <= GAP;
              shot_valid_q <= 1'b0;
              gap_cnt_q    <= GAP_W'(BURST_GAP - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q      <= ISSUE;
            shot_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        COOLDOWN: begin
          if (cd_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cd_cnt_q <= cd_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          shot_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign angle_out  = angle_q;
  assign shot_valid = shot_valid_q;
  assign shot_angle = shot_angle_q;
  assign shot_mode  = shot_mode_q;
  assign busy       = busy_q;

endmodule
